// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and a width helper.
package uart_pkg;

  // Receiver state encoding, 3-bit state register.
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd3;
  localparam logic [2:0] RX_PARITY = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd6;

  typedef enum logic [2:0] {
    StIdle   = RX_IDLE,
    StStart  = RX_START,
    StData   = RX_DATA,
    StParity = RX_PARITY,
    StStop   = RX_STOP
  } rx_state_e;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so it can be reused on other async lines.
module uart_rx_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic stage1_q;
  logic stage2_q;

  // Two-stage metastability filter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= RESET_VALUE;
      stage2_q <= RESET_VALUE;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx at CLOCKS_PER_PULSE clocks per bit, samples
// mid-bit, recovers LSB-first frames and strobes each word out with error flags.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  rx_busy
);

  localparam int unsigned CW = clog2_min1(CLOCKS_PER_PULSE);
  localparam int unsigned BW = clog2_min1(DATA_WIDTH);
  localparam logic [CW-1:0] ClkHalf = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] ClkLast = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         c_clocks_q, c_clocks_d;
  logic [BW-1:0]         c_bits_q, c_bits_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_done;  // stop bit sampled this cycle
`ifdef UART_RX_PARITY_EN
  logic                  par_err_q, par_err_d;
`endif

  uart_rx_sync #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Next-state logic: bit timing counters, shift register and frame completion.
  always_comb begin
    state_d    = state_q;
    c_clocks_d = c_clocks_q;
    c_bits_d   = c_bits_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d    = StStart;
          c_clocks_d = '0;
          c_bits_d   = '0;
        end
      end
      StStart: begin
        if (c_clocks_q == ClkHalf) begin
          c_clocks_d = '0;
          // A line that is high again at mid-start was a glitch, not a frame.
          state_d    = rx_s ? StIdle : StData;
        end else begin
          c_clocks_d = c_clocks_q + 1'b1;
        end
      end
      StData: begin
        if (c_clocks_q == ClkLast) begin
          c_clocks_d        = '0;
          shift_d[c_bits_q] = rx_s;
          if (c_bits_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            c_bits_d = c_bits_q + 1'b1;
          end
        end else begin
          c_clocks_d = c_clocks_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (c_clocks_q == ClkLast) begin
          c_clocks_d = '0;
          par_err_d  = rx_s ^ (^shift_q);
          state_d    = StStop;
        end else begin
          c_clocks_d = c_clocks_q + 1'b1;
        end
      end
`endif
      StStop: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (c_clocks_q == ClkLast) begin
          c_clocks_d = '0;
          frame_done = 1'b1;
          state_d    = StIdle;
        end else begin
          c_clocks_d = c_clocks_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      c_clocks_q  <= '0;
      c_bits_q    <= '0;
      shift_q     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_clocks_q <= c_clocks_d;
      c_bits_q   <= c_bits_d;
      shift_q    <= shift_d;
      data_valid <= frame_done;
      if (frame_done) begin
        data_out    <= shift_q;
        frame_error <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Hold the parity result until the stop-bit strobe publishes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q    <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      if (frame_done) begin
        parity_error <= par_err_q;
      end
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  assign rx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames through a scoreboard plus
// hand sequences for false start, back-to-back frames and mid-frame reset.
module tb_uart_rx;

  localparam int unsigned CPP = 16;
  localparam int unsigned DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned NBITS = DW + 2 + (PAR_EN ? 1 : 0);
  // Edge of the data_valid strobe relative to edge 0 of the start bit.
  localparam int unsigned LAT = 2 + CPP / 2 + (NBITS - 1) * CPP;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_error;
  logic          parity_error;
  logic          rx_busy;

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          fe;
    logic          pe;
    int            edge_n;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop_bit;
    logic          par_bit;
    int            gap;
    logic [DW-1:0] exp_data;
    logic          exp_fe;
    logic          exp_pe;
  } vec_t;

  exp_t sb_q[$];
  int   strobe_edges[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One bit period; returns 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input logic par_bit,
                            input logic [DW-1:0] exp_data, input logic exp_fe,
                            input logic exp_pe);
    exp_t e;
    e.data   = exp_data;
    e.fe     = exp_fe;
    e.pe     = exp_pe;
    e.edge_n = edge_cnt + 1 + LAT;
    sb_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_valid) begin
      strobe_edges.push_back(edge_cnt);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: data_out=%0h, required no strobe", data_out);
      end else begin
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("frame_error", 32'(frame_error), 32'(e.fe));
        check("parity_error", 32'(parity_error), 32'(e.pe));
        check("strobe_edge", 32'(edge_cnt), 32'(e.edge_n));
        check("busy_at_strobe", 32'(rx_busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  int   n0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 20,      8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 2 * CPP, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 20,      8'h11, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 20,      8'h07, 1'b0, PAR_EN};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 20,      8'h07, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 20,      8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 20,      8'h01, 1'b0, 1'b0};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_parity_error", 32'(parity_error), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(4);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_bit, vecs[i].exp_data,
                 vecs[i].exp_fe, vecs[i].exp_pe);
      idle(vecs[i].gap);
      check("busy_after_frame", 32'(rx_busy), 32'd0);
    end

    // False start: 4 low cycles must not produce a frame.
    n0 = strobe_edges.size();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("false_start_busy_rise", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    repeat (CPP / 2 + 3) @(posedge clk);
    #1;
    check("false_start_busy_fall", 32'(rx_busy), 32'd0);
    idle(2 * CPP);
    check("false_start_no_strobe", 32'(strobe_edges.size() - n0), 32'd0);

    // Back-to-back frames with no idle between them.
    n0 = strobe_edges.size();
    send_frame(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    idle(20);
    check("b2b_strobes", 32'(strobe_edges.size() - n0), 32'd2);
    if (strobe_edges.size() - n0 == 2)
      check("b2b_spacing", 32'(strobe_edges[n0 + 1] - strobe_edges[n0]), 32'(NBITS * CPP));

    // Reset pulse during data bit 3 aborts the frame.
    n0 = strobe_edges.size();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CPP / 2) @(posedge clk);
    #1;
    check("busy_mid_frame", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_data_valid", 32'(data_valid), 32'd0);
    check("abort_frame_error", 32'(frame_error), 32'd0);
    check("abort_parity_error", 32'(parity_error), 32'd0);
    check("abort_rx_busy", 32'(rx_busy), 32'd0);
    idle(2 * CPP);
    check("abort_no_strobe", 32'(strobe_edges.size() - n0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    idle(20);

    for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
